// File: rtl/vga_if.sv
// VGA pixel-stream bundle: raster position, sync/blanking and colour passed between drawing stages.
// The source end uses out (alias master); each consumer uses in (alias slave).
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport out    (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport in     (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source for 800x600@60 (40 MHz pixel clock): position counters, sync/blanking,
// a frame-start strobe and a free-running frame counter. No picture is generated (rgb = 0).
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  vga_if.out                vga_out,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLNK_LO = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLNK_LO = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  // Counters are 11 bits wide, so the totals must fit in 0..2047.
  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2048");
    end
  endgenerate

  function automatic logic in_win(input logic [10:0] c, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic logic sync_level(input logic active);
    return active ? SYNC_ON : ~SYNC_ON;
  endfunction

  logic [10:0]       hcount_p0;
  logic [10:0]       vcount_p0;
  logic              hsync_p0;
  logic              hblnk_p0;
  logic              vsync_p0;
  logic              vblnk_p0;
  logic              frame_start_p0;
  logic [FCNT_W-1:0] frame_cnt_p0;

  logic              h_wrap;
  logic              v_wrap;
  logic              frame_wrap;
  logic [10:0]       h_nxt;
  logic [10:0]       v_nxt;

  assign h_wrap     = (hcount_p0 == H_LAST);
  assign v_wrap     = (vcount_p0 == V_LAST);
  assign frame_wrap = h_wrap && v_wrap;
  assign h_nxt      = h_wrap ? 11'd0 : hcount_p0 + 11'd1;
  assign v_nxt      = !h_wrap ? vcount_p0 : (v_wrap ? 11'd0 : vcount_p0 + 11'd1);

  // Stage p0: decode from the next position so every field lines up with the count it shows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_p0      <= 11'd0;
      vcount_p0      <= 11'd0;
      hsync_p0       <= ~SYNC_ON;
      hblnk_p0       <= 1'b0;
      vsync_p0       <= ~SYNC_ON;
      vblnk_p0       <= 1'b0;
      frame_start_p0 <= 1'b0;
      frame_cnt_p0   <= '0;
    end else if (en) begin
      hcount_p0      <= h_nxt;
      vcount_p0      <= v_nxt;
      hsync_p0       <= sync_level(in_win(h_nxt, H_SYNC_LO, H_SYNC_HI));
      hblnk_p0       <= in_win(h_nxt, H_BLNK_LO, H_LAST);
      vsync_p0       <= sync_level(in_win(v_nxt, V_SYNC_LO, V_SYNC_HI));
      vblnk_p0       <= in_win(v_nxt, V_BLNK_LO, V_LAST);
      frame_start_p0 <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt_p0 <= frame_cnt_p0 + FCNT_W'(1);
      end
    end else begin
      // A stalled cycle must not stretch the strobe.
      frame_start_p0 <= 1'b0;
    end
  end

  assign vga_out.hcount = hcount_p0;
  assign vga_out.vcount = vcount_p0;
  assign vga_out.hsync  = hsync_p0;
  assign vga_out.hblnk  = hblnk_p0;
  assign vga_out.vsync  = vsync_p0;
  assign vga_out.vblnk  = vblnk_p0;
  assign vga_out.rgb    = 12'h000;
  assign frame_start    = frame_start_p0;
  assign frame_cnt      = frame_cnt_p0;

endmodule
